// File: rtl/request_scheduler_if.sv
// Request/sensor/transmit signal bundle for request_scheduler.
// slave is the scheduler's view; master is the driving side.
interface request_scheduler_if;
    logic       rx_valid;
    logic [7:0] rx_cmd;
    logic [7:0] rx_addr;
    logic       sens_start;
    logic [4:0] sens_addr;
    logic       sens_done;
    logic       sens_error;
    logic [7:0] sens_hum;
    logic [7:0] sens_temp;
    logic       tx_start;
    logic [7:0] tx_cmd;
    logic [7:0] tx_val;
    logic       tx_busy;
    logic       cont_active;
    logic       overflow;

    modport slave (
        input  rx_valid, rx_cmd, rx_addr, sens_done, sens_error, sens_hum, sens_temp, tx_busy,
        output sens_start, sens_addr, tx_start, tx_cmd, tx_val, cont_active, overflow
    );

    modport master (
        output rx_valid, rx_cmd, rx_addr, sens_done, sens_error, sens_hum, sens_temp, tx_busy,
        input  sens_start, sens_addr, tx_start, tx_cmd, tx_val, cont_active, overflow
    );
endinterface

// File: rtl/request_scheduler.sv
// Sensor request scheduler: decodes two-byte host requests, runs sensor transactions,
// answers through the transmitter, and polls in continuous mode.
module request_scheduler #(
    parameter int unsigned NUM_ADDR       = 32,
    parameter int unsigned POLL_PERIOD    = 50_000_000,
    parameter int unsigned SENSOR_TIMEOUT = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    request_scheduler_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, DECODE, SENSE_REQ, SENSE_WAIT, SEND, SEND_WAIT} state_t;

    localparam logic [31:0] POLL_LAST = 32'(POLL_PERIOD - 1);
    localparam logic [31:0] TO_LAST   = 32'(SENSOR_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_cmd_q, pend_cmd_d, pend_addr_q, pend_addr_d;
    logic [7:0]  cur_cmd_q, cur_cmd_d, cur_addr_q, cur_addr_d;
    logic [7:0]  resp_cmd_q, resp_cmd_d, resp_val_q, resp_val_d;
    logic        cont_active_q, cont_active_d, cont_hum_q, cont_hum_d;
    logic [4:0]  cont_addr_q, cont_addr_d;
    logic [31:0] poll_cnt_q, poll_cnt_d, to_cnt_q, to_cnt_d;
    logic        sens_start_q, sens_start_d;
    logic [4:0]  sens_addr_q, sens_addr_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_cmd_q, tx_cmd_d, tx_val_q, tx_val_d;
    logic        busy_seen_q, busy_seen_d;
    logic        overflow_q, overflow_d;
    logic        pend_take, poll_restart, poll_expired, cur_is_cont;

    assign poll_expired = (poll_cnt_q == POLL_LAST);
    assign cur_is_cont  = (cur_cmd_q == 8'h03) || (cur_cmd_q == 8'h04);

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_cmd_d    = pend_cmd_q;
        pend_addr_d   = pend_addr_q;
        cur_cmd_d     = cur_cmd_q;
        cur_addr_d    = cur_addr_q;
        resp_cmd_d    = resp_cmd_q;
        resp_val_d    = resp_val_q;
        cont_active_d = cont_active_q;
        cont_hum_d    = cont_hum_q;
        cont_addr_d   = cont_addr_q;
        poll_cnt_d    = poll_cnt_q;
        to_cnt_d      = to_cnt_q;
        sens_start_d  = 1'b0;
        sens_addr_d   = sens_addr_q;
        tx_start_d    = 1'b0;
        tx_cmd_d      = tx_cmd_q;
        tx_val_d      = tx_val_q;
        busy_seen_d   = busy_seen_q;
        overflow_d    = overflow_q;
        pend_take     = 1'b0;
        poll_restart  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    pend_take  = 1'b1;
                    cur_cmd_d  = pend_cmd_q;
                    cur_addr_d = pend_addr_q;
                    state_d    = DECODE;
                end else if (cont_active_q && poll_expired) begin
                    // A poll replays the latched continuous request as if it were new.
                    cur_cmd_d  = cont_hum_q ? 8'h04 : 8'h03;
                    cur_addr_d = {3'b000, cont_addr_q};
                    state_d    = SENSE_REQ;
                end
            end
            DECODE: begin
                if (cur_cmd_q > 8'h05 || 32'(cur_addr_q) >= NUM_ADDR) begin
                    resp_cmd_d = 8'hEE;
                    resp_val_d = cur_cmd_q;
                    state_d    = SEND;
                end else if (cur_cmd_q == 8'h05) begin
                    cont_active_d = 1'b0;
                    resp_cmd_d    = 8'h0A;
                    resp_val_d    = 8'h00;
                    state_d       = SEND;
                end else begin
                    state_d = SENSE_REQ;
                end
            end
            SENSE_REQ: begin
                sens_start_d = 1'b1;
                sens_addr_d  = cur_addr_q[4:0];
                to_cnt_d     = '0;
                poll_restart = cur_is_cont;
                state_d      = SENSE_WAIT;
            end
            SENSE_WAIT: begin
                if (bus.sens_done && !bus.sens_error) begin
                    case (cur_cmd_q)
                        8'h00:        begin resp_cmd_d = 8'h07; resp_val_d = 8'h00;         end
                        8'h01, 8'h03: begin resp_cmd_d = 8'h09; resp_val_d = bus.sens_temp; end
                        default:      begin resp_cmd_d = 8'h08; resp_val_d = bus.sens_hum;  end
                    endcase
                    if (cur_is_cont) begin
                        cont_active_d = 1'b1;
                        cont_hum_d    = (cur_cmd_q == 8'h04);
                        cont_addr_d   = cur_addr_q[4:0];
                    end
                    state_d = SEND;
                end else if (bus.sens_done || to_cnt_q == TO_LAST) begin
                    resp_cmd_d    = 8'h1F;
                    resp_val_d    = 8'h00;
                    cont_active_d = 1'b0;
                    state_d       = SEND;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_cmd_d    = resp_cmd_q;
                    tx_val_d    = resp_val_q;
                    tx_start_d  = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                if (bus.tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Consumption and capture may coincide, so a full-but-draining buffer still accepts.
        if (bus.rx_valid) begin
            if (!pend_valid_q || pend_take) begin
                pend_valid_d = 1'b1;
                pend_cmd_d   = bus.rx_cmd;
                pend_addr_d  = bus.rx_addr;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (pend_take) begin
            pend_valid_d = 1'b0;
        end

        // Saturates at expiry so a late-serviced poll never stacks up.
        if (!cont_active_q || poll_restart) begin
            poll_cnt_d = '0;
        end else if (!poll_expired) begin
            poll_cnt_d = poll_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pend_valid_q  <= 1'b0;
            pend_cmd_q    <= '0;
            pend_addr_q   <= '0;
            cur_cmd_q     <= '0;
            cur_addr_q    <= '0;
            resp_cmd_q    <= '0;
            resp_val_q    <= '0;
            cont_active_q <= 1'b0;
            cont_hum_q    <= 1'b0;
            cont_addr_q   <= '0;
            poll_cnt_q    <= '0;
            to_cnt_q      <= '0;
            sens_start_q  <= 1'b0;
            sens_addr_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_cmd_q      <= '0;
            tx_val_q      <= '0;
            busy_seen_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_cmd_q    <= pend_cmd_d;
            pend_addr_q   <= pend_addr_d;
            cur_cmd_q     <= cur_cmd_d;
            cur_addr_q    <= cur_addr_d;
            resp_cmd_q    <= resp_cmd_d;
            resp_val_q    <= resp_val_d;
            cont_active_q <= cont_active_d;
            cont_hum_q    <= cont_hum_d;
            cont_addr_q   <= cont_addr_d;
            poll_cnt_q    <= poll_cnt_d;
            to_cnt_q      <= to_cnt_d;
            sens_start_q  <= sens_start_d;
            sens_addr_q   <= sens_addr_d;
            tx_start_q    <= tx_start_d;
            tx_cmd_q      <= tx_cmd_d;
            tx_val_q      <= tx_val_d;
            busy_seen_q   <= busy_seen_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.sens_start  = sens_start_q;
    assign bus.sens_addr   = sens_addr_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_cmd      = tx_cmd_q;
    assign bus.tx_val      = tx_val_q;
    assign bus.cont_active = cont_active_q;
    assign bus.overflow    = overflow_q;
endmodule
